matrix_scoreboard: RTL and testbench
====================================

MATRIX_SCOREBOARD -- requirements
Module: matrix_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_MREGS, default 16: number of matrix registers tracked; the index width is 4 bits.
REQ-002 The block SHALL have parameter LDST_DEPTH, default 2: maximum number of outstanding matrix LD/ST operations.
REQ-003 The block SHALL have the following ports, with one clock and an asynchronous active-low reset:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset; asynchronous assertion, active-low
- disp_valid  in  1  decoded instruction present
- disp_ready  out  1  instruction accepted this cycle
- fu_t  in  2  0=FU_S_T, 1=FU_M_T, 2=FU_G_T, 3=reserved
- m_mem_type  in  2  0=none, 1=M_LOAD, 2=M_STORE
- m_reg_write  in  1  instruction writes matrix_rd
- matrix_rd  in  4  LD destination or ST source
- gemm_rs1, gemm_rs2, gemm_rs3  in  4 each  GEMM sources
- gemm_rd  in  4  GEMM destination
- s_issue  out  1  scalar dispatch strobe
- ldst_issue  out  1  matrix LD/ST dispatch strobe
- gemm_issue  out  1  GEMM dispatch strobe
- ldst_done  in  1  one matrix LD/ST completed
- ldst_done_rd  in  4  register released by that completion (load destination)
- ldst_done_wr  in  1  completion carries a register write
- gemm_done  in  1  GEMM completed; releases the latched gemm_rd
- flush  in  1  single-cycle flush request
- busy_mask  out  NUM_MREGS  registered pending-write bits
- ldst_cnt  out  2  outstanding LD/ST count
- state  out  2  0=RUN, 1=DRAIN

Function
REQ-004 The block SHALL assert disp_ready combinationally from registered state and current inputs; an instruction is issued iff disp_valid&&disp_ready.
REQ-005 For FU_S_T, disp_ready SHALL be 1 in RUN, and s_issue SHALL equal disp_valid&&disp_ready.
REQ-006 For FU_M_T M_LOAD, the block SHALL require ldst_cnt<LDST_DEPTH (or a same-cycle ldst_done) and busy_mask[matrix_rd]==0 (WAW).
REQ-007 For FU_M_T M_STORE, the block SHALL require ldst_cnt<LDST_DEPTH (or a same-cycle ldst_done) and busy_mask[matrix_rd]==0 (RAW); a store SHALL NOT set any busy bit.
REQ-008 For FU_G_T, the block SHALL require gemm_busy==0 and busy bits clear for gemm_rs1, gemm_rs2, gemm_rs3 and gemm_rd.
REQ-009 For fu_t=3, or FU_M_T with m_mem_type=0, the block SHALL hold disp_ready=0.
REQ-010 The block SHALL NOT bypass: a busy bit cleared by a done in cycle N gates dispatch only from cycle N+1.
REQ-011 On a load issue with m_reg_write=1, the block SHALL set busy_mask[matrix_rd] on the next edge.
REQ-012 On a GEMM issue, the block SHALL set busy_mask[gemm_rd] and gemm_busy, and latch gemm_rd internally.
REQ-013 On ldst_done&&ldst_done_wr, the block SHALL clear busy_mask[ldst_done_rd]; on gemm_done, it SHALL clear busy_mask[latched rd] and gemm_busy.
REQ-014 When a set and a clear target the same bit in one cycle, set SHALL win (only reachable through a malformed done; for assertion coverage).
REQ-015 ldst_cnt SHALL change by +1 on issue only, -1 on done only, and 0 on both.
REQ-016 A done arriving with ldst_cnt==0 SHALL be ignored; the counter SHALL never wrap.
REQ-017 A gemm_done arriving while gemm_busy==0 SHALL be ignored.
REQ-018 FSM transitions:
- RUN -> DRAIN on flush
- DRAIN -> RUN when ldst_cnt==0, gemm_busy==0 and busy_mask==0, evaluated on registered values
- in DRAIN, disp_ready=0 for all fu_t
- flush while in DRAIN has no effect
REQ-019 Issue strobes SHALL be mutually exclusive and have 0-cycle latency from disp_valid.

Reset
REQ-020 While nRST=0, the block SHALL hold busy_mask=0, ldst_cnt=0, gemm_busy=0, state=RUN and the latched gemm_rd=0, taking effect asynchronously mid-operation.
REQ-021 During reset, the block SHALL hold all issue strobes low and disp_ready=0; dones arriving during reset SHALL be dropped.

Verification
REQ-022 Load m3 issued, then a GEMM with rs1=3 presented -> disp_ready=0 until one cycle after ldst_done with rd=3 and wr=1; gemm_issue then fires.
REQ-023 Two loads to m1 and m2 issued back to back, third load presented -> ldst_cnt=2 and disp_ready=0; a ldst_done in the same cycle gives disp_ready=1 with ldst_cnt staying 2.
REQ-024 GEMM rd=5 issued, second GEMM presented -> stalls; gemm_done -> busy_mask[5]=0 and the second issues on the next cycle.
REQ-025 Flush with a load pending on m7 -> state=DRAIN and scalar ops blocked; ldst_done clears m7 -> state=RUN on the following cycle.
REQ-026 nRST pulsed low mid-GEMM with busy_mask=16'h0021 -> all outputs zero immediately; a late gemm_done after reset is ignored.
REQ-027 Spurious ldst_done at ldst_cnt=0 -> count stays 0 and busy_mask is unchanged.

Source files
------------

// File: rtl/matrix_scoreboard.sv
// Matrix register scoreboard: tracks pending writes to matrix registers and
// gates dispatch of scalar, matrix LD/ST and GEMM instructions on hazards.
module matrix_scoreboard #(
    parameter int unsigned NUM_MREGS  = 16,
    parameter int unsigned LDST_DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [1:0]           fu_t,
    input  logic [1:0]           m_mem_type,
    input  logic                 m_reg_write,
    input  logic [3:0]           matrix_rd,
    input  logic [3:0]           gemm_rs1,
    input  logic [3:0]           gemm_rs2,
    input  logic [3:0]           gemm_rs3,
    input  logic [3:0]           gemm_rd,
    output logic                 s_issue,
    output logic                 ldst_issue,
    output logic                 gemm_issue,
    input  logic                 ldst_done,
    input  logic [3:0]           ldst_done_rd,
    input  logic                 ldst_done_wr,
    input  logic                 gemm_done,
    input  logic                 flush,
    output logic [NUM_MREGS-1:0] busy_mask,
    output logic [1:0]           ldst_cnt,
    output logic [1:0]           state
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] FU_S_T   = 2'd0;
    localparam logic [1:0] FU_M_T   = 2'd1;
    localparam logic [1:0] FU_G_T   = 2'd2;
    localparam logic [1:0] M_LOAD   = 2'd1;
    localparam logic [1:0] M_STORE  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [NUM_MREGS-1:0] r_busy;
    logic [NUM_MREGS-1:0] w_busy_nxt;
    logic [NUM_MREGS-1:0] w_set;
    logic [NUM_MREGS-1:0] w_clr;
    logic [CNT_W-1:0]     r_ldst_cnt;
    logic [CNT_W-1:0]     w_ldst_cnt_nxt;
    logic                 r_gemm_busy;
    logic [IDX_W-1:0]     r_gemm_rd;

    logic                 w_ready;
    logic                 w_issue;
    logic                 w_ld_issue;
    logic                 w_ldst_room;
    logic                 w_done_ok;
    logic                 w_gdone_ok;
    logic                 w_drained;

    // Completions are only honoured when something is actually outstanding
    assign w_done_ok  = ldst_done && (r_ldst_cnt != '0);
    assign w_gdone_ok = gemm_done && r_gemm_busy;
    assign w_drained  = (r_ldst_cnt == '0) && !r_gemm_busy && (r_busy == '0);

    // A same-cycle completion frees a LD/ST slot for this cycle's dispatch
    assign w_ldst_room = (r_ldst_cnt < CNT_W'(LDST_DEPTH)) || w_done_ok;

    // Dispatch readiness from registered busy state only (no done bypass)
    always_comb begin
        w_ready = 1'b0;
        if (nRST && (r_state == ST_RUN)) begin
            case (fu_t)
                FU_S_T: w_ready = 1'b1;
                FU_M_T: begin
                    if ((m_mem_type == M_LOAD) || (m_mem_type == M_STORE)) begin
                        w_ready = w_ldst_room && !r_busy[matrix_rd];
                    end
                end
                FU_G_T: begin
                    w_ready = !r_gemm_busy
                              && !r_busy[gemm_rs1] && !r_busy[gemm_rs2]
                              && !r_busy[gemm_rs3] && !r_busy[gemm_rd];
                end
                default: w_ready = 1'b0;
            endcase
        end
    end

    assign w_issue    = disp_valid && w_ready;
    assign disp_ready = w_ready;
    assign s_issue    = w_issue && (fu_t == FU_S_T);
    assign ldst_issue = w_issue && (fu_t == FU_M_T);
    assign gemm_issue = w_issue && (fu_t == FU_G_T);
    assign w_ld_issue = ldst_issue && (m_mem_type == M_LOAD);

    // Busy-bit set/clear vectors; set is applied after clear so it wins
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_ld_issue && m_reg_write) w_set[matrix_rd] = 1'b1;
        if (gemm_issue)                w_set[gemm_rd]   = 1'b1;
        if (w_done_ok && ldst_done_wr) w_clr[ldst_done_rd] = 1'b1;
        if (w_gdone_ok)                w_clr[r_gemm_rd] = 1'b1;
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    // Outstanding LD/ST count: issue and done in one cycle cancel out
    always_comb begin
        w_ldst_cnt_nxt = r_ldst_cnt;
        case ({ldst_issue, w_done_ok})
            2'b10:   w_ldst_cnt_nxt = r_ldst_cnt + CNT_W'(1);
            2'b01:   w_ldst_cnt_nxt = r_ldst_cnt - CNT_W'(1);
            default: w_ldst_cnt_nxt = r_ldst_cnt;
        endcase
    end

    // Next-state logic: flush drains, return to RUN once fully idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (flush)     w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_state_nxt = ST_RUN;
            default:                 w_state_nxt = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // Scoreboard registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_busy      <= '0;
            r_ldst_cnt  <= '0;
            r_gemm_busy <= 1'b0;
            r_gemm_rd   <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_ldst_cnt <= w_ldst_cnt_nxt;
            if (gemm_issue) begin
                r_gemm_busy <= 1'b1;
                r_gemm_rd   <= gemm_rd;
            end else if (w_gdone_ok) begin
                r_gemm_busy <= 1'b0;
            end
        end
    end

    assign busy_mask = r_busy;
    assign ldst_cnt  = r_ldst_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_matrix_scoreboard.sv
// Directed bench for matrix_scoreboard: hazard stalls, LD/ST depth, GEMM
// serialisation, flush/drain and asynchronous reset.
module tb_matrix_scoreboard;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        disp_valid;
    logic        disp_ready;
    logic [1:0]  fu_t;
    logic [1:0]  m_mem_type;
    logic        m_reg_write;
    logic [3:0]  matrix_rd;
    logic [3:0]  gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd;
    logic        s_issue, ldst_issue, gemm_issue;
    logic        ldst_done;
    logic [3:0]  ldst_done_rd;
    logic        ldst_done_wr;
    logic        gemm_done;
    logic        flush;
    logic [15:0] busy_mask;
    logic [1:0]  ldst_cnt;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    matrix_scoreboard #(.NUM_MREGS(16), .LDST_DEPTH(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .fu_t(fu_t), .m_mem_type(m_mem_type), .m_reg_write(m_reg_write),
        .matrix_rd(matrix_rd),
        .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3),
        .gemm_rd(gemm_rd),
        .s_issue(s_issue), .ldst_issue(ldst_issue), .gemm_issue(gemm_issue),
        .ldst_done(ldst_done), .ldst_done_rd(ldst_done_rd),
        .ldst_done_wr(ldst_done_wr), .gemm_done(gemm_done), .flush(flush),
        .busy_mask(busy_mask), .ldst_cnt(ldst_cnt), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 0; fu_t = 0; m_mem_type = 0; m_reg_write = 0; matrix_rd = 0;
        gemm_rs1 = 0; gemm_rs2 = 0; gemm_rs3 = 0; gemm_rd = 0;
        ldst_done = 0; ldst_done_rd = 0; ldst_done_wr = 0; gemm_done = 0; flush = 0;
    endtask

    // Advance to the next falling edge and clear all strobes
    task automatic step();
        @(negedge CLK);
        idle();
    endtask

    task automatic pres_load(input logic [3:0] rd);
        disp_valid = 1; fu_t = 2'd1; m_mem_type = 2'd1; m_reg_write = 1; matrix_rd = rd;
    endtask

    task automatic pres_store(input logic [3:0] rd);
        disp_valid = 1; fu_t = 2'd1; m_mem_type = 2'd2; m_reg_write = 0; matrix_rd = rd;
    endtask

    task automatic pres_gemm(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        disp_valid = 1; fu_t = 2'd2; gemm_rs1 = a; gemm_rs2 = b; gemm_rs3 = c; gemm_rd = d;
    endtask

    task automatic done_ld(input logic [3:0] rd, input logic wr);
        ldst_done = 1; ldst_done_rd = rd; ldst_done_wr = wr;
    endtask

    initial begin
        idle();
        nRST = 0;
        // Reset: outputs cleared, dispatch and dones dropped
        @(negedge CLK);
        disp_valid = 1; fu_t = 0; ldst_done = 1; gemm_done = 1; #1;
        chk("rst_ready", 32'(disp_ready), 0);
        chk("rst_s_issue", 32'(s_issue), 0);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_cnt", 32'(ldst_cnt), 0);
        chk("rst_state", 32'(state), 0);
        step(); nRST = 1;

        // Scalar passes in RUN
        step(); disp_valid = 1; fu_t = 0; #1;
        chk("s_ready", 32'(disp_ready), 1);
        chk("s_strobes", 32'({s_issue, ldst_issue, gemm_issue}), 32'b100);
        // Reserved fu_t and M_T without mem type never ready
        step(); disp_valid = 1; fu_t = 2'd3; #1;
        chk("fu3_ready", 32'(disp_ready), 0);
        step(); disp_valid = 1; fu_t = 2'd1; m_mem_type = 0; #1;
        chk("mnone_ready", 32'(disp_ready), 0);

        // Load m3, GEMM reading m3 stalls until a cycle after the done
        step(); pres_load(3); #1;
        chk("ld3_strobes", 32'({s_issue, ldst_issue, gemm_issue}), 32'b010);
        step(); pres_gemm(3, 0, 0, 4); #1;
        chk("ld3_busy", 32'(busy_mask), 32'h0008);
        chk("ld3_cnt", 32'(ldst_cnt), 1);
        chk("g_raw_stall", 32'(disp_ready), 0);
        step(); pres_gemm(3, 0, 0, 4); done_ld(3, 1); #1;
        chk("g_nobypass", 32'(disp_ready), 0);
        chk("g_nobypass_iss", 32'(gemm_issue), 0);
        step(); pres_gemm(3, 0, 0, 4); #1;
        chk("g_after_done_busy", 32'(busy_mask), 0);
        chk("g_after_done_iss", 32'(gemm_issue), 1);
        step(); gemm_done = 1; #1;
        chk("g4_busy", 32'(busy_mask), 32'h0010);
        step(); #1;
        chk("g4_release", 32'(busy_mask), 0);

        // Two loads fill LD/ST depth; third issues only with a same-cycle done
        step(); pres_load(1); #1;
        chk("ld1_iss", 32'(ldst_issue), 1);
        step(); pres_load(2); #1;
        chk("ld2_iss", 32'(ldst_issue), 1);
        step(); pres_load(9); #1;
        chk("full_cnt", 32'(ldst_cnt), 2);
        chk("full_ready", 32'(disp_ready), 0);
        step(); pres_load(9); done_ld(1, 1); #1;
        chk("full_done_ready", 32'(disp_ready), 1);
        chk("full_done_iss", 32'(ldst_issue), 1);
        step(); done_ld(2, 1); #1;
        chk("swap_cnt", 32'(ldst_cnt), 2);
        chk("swap_busy", 32'(busy_mask), 32'h0204);
        step(); done_ld(9, 1); #1;
        chk("drain1_busy", 32'(busy_mask), 32'h0200);
        step(); #1;
        chk("drain2_cnt", 32'(ldst_cnt), 0);
        chk("drain2_busy", 32'(busy_mask), 0);

        // Store: RAW against pending load, no busy bit set by store
        step(); pres_load(6); #1;
        step(); pres_store(6); #1;
        chk("st_raw_ready", 32'(disp_ready), 0);
        step(); pres_store(8); #1;
        chk("st_ok_iss", 32'(ldst_issue), 1);
        step(); #1;
        chk("st_busy", 32'(busy_mask), 32'h0040);
        chk("st_cnt", 32'(ldst_cnt), 2);
        // Spurious gemm_done while GEMM idle must not touch m6
        gemm_done = 1;
        step(); done_ld(6, 1); #1;
        chk("spur_gdone_busy", 32'(busy_mask), 32'h0040);
        step(); done_ld(8, 0); #1;
        chk("st_done_cnt", 32'(ldst_cnt), 1);
        step(); #1;
        chk("st_all_cnt", 32'(ldst_cnt), 0);
        chk("st_all_busy", 32'(busy_mask), 0);

        // GEMM rd=5; spurious ldst_done at count 0; second GEMM waits for done
        step(); pres_gemm(0, 1, 2, 5); #1;
        chk("g5_iss", 32'(gemm_issue), 1);
        step(); done_ld(5, 1); pres_gemm(7, 8, 9, 6); #1;
        chk("g5_busy", 32'(busy_mask), 32'h0020);
        chk("g_serial_stall", 32'(disp_ready), 0);
        step(); pres_gemm(7, 8, 9, 6); gemm_done = 1; #1;
        chk("spur_ld_busy", 32'(busy_mask), 32'h0020);
        chk("spur_ld_cnt", 32'(ldst_cnt), 0);
        chk("gdone_nobypass", 32'(disp_ready), 0);
        step(); pres_gemm(7, 8, 9, 6); #1;
        chk("g5_cleared", 32'(busy_mask), 0);
        chk("g6_iss", 32'(gemm_issue), 1);
        step(); gemm_done = 1; #1;
        chk("g6_busy", 32'(busy_mask), 32'h0040);
        step(); #1;
        chk("g6_release", 32'(busy_mask), 0);

        // Flush with m7 pending: DRAIN blocks scalars until idle
        step(); pres_load(7); #1;
        step(); flush = 1; #1;
        step(); disp_valid = 1; fu_t = 0; flush = 1; #1;
        chk("drain_state", 32'(state), 1);
        chk("drain_s_ready", 32'(disp_ready), 0);
        chk("drain_s_iss", 32'(s_issue), 0);
        step(); disp_valid = 1; fu_t = 0; done_ld(7, 1); #1;
        chk("drain_still", 32'(state), 1);
        step(); disp_valid = 1; fu_t = 0; #1;
        chk("drain_idle_busy", 32'(busy_mask), 0);
        chk("drain_idle_state", 32'(state), 1);
        step(); disp_valid = 1; fu_t = 0; #1;
        chk("run_state", 32'(state), 0);
        chk("run_s_iss", 32'(s_issue), 1);

        // Async reset mid-GEMM with busy_mask=0x0021
        step(); pres_load(0); #1;
        step(); pres_gemm(1, 2, 3, 5); #1;
        step(); #1;
        chk("pre_rst_busy", 32'(busy_mask), 32'h0021);
        #2; nRST = 0; disp_valid = 1; fu_t = 0; #1;
        chk("arst_busy", 32'(busy_mask), 0);
        chk("arst_cnt", 32'(ldst_cnt), 0);
        chk("arst_state", 32'(state), 0);
        chk("arst_strobes", 32'({disp_ready, s_issue, ldst_issue, gemm_issue}), 0);
        step(); nRST = 1;
        step(); gemm_done = 1; #1;
        step(); pres_gemm(1, 2, 3, 5); #1;
        chk("late_gdone_busy", 32'(busy_mask), 0);
        chk("post_rst_g_iss", 32'(gemm_issue), 1);
        step(); #1;
        chk("post_rst_g_busy", 32'(busy_mask), 32'h0020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
